cntdn4_timer: RTL and testbench
===============================

# cntdn4_timer

Loadable down-counter with prescaler and terminal-count detection, the count-down counterpart of the 4-bit up counter (`cntr4`) in the Mastermind datapath. It holds a value loaded by the controller (guesses remaining or turn timer). It decrements it once every `PRESCALE` enabled clocks and flags completion with a one-cycle terminal-count pulse. It never wraps below zero; the game FSM uses `tc`/`zero` to end a turn or the game.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `PRESCALE`, default 4: enabled clocks per decrement. Must be ≥ 1. Prescaler register width is clog2(`PRESCALE`), minimum 1.

- `clk`: input, 1 bit. Rising-edge clock; the only clock.
- `reset`: input, 1 bit. Asynchronous, active-high reset.
- `load`: input, 1 bit. Synchronous load strobe.
- `ld_val`: input, `WIDTH` bits. Value captured on `load`.
- `en`: input, 1 bit. Count enable. Low pauses the countdown.
- `q`: output, `WIDTH` bits. Current count, registered.
- `zero`: output, 1 bit. High whenever `q` == 0. Decoded from the `q` register.
- `tc`: output, 1 bit. Registered one-cycle pulse, high in the cycle `q` first becomes 0 by counting.
- `busy`: output, 1 bit. High in RUN or PAUSE. Registered or decoded from the state register.

## Operation
- **FSM states:** IDLE, RUN, PAUSE, DONE.
- **Reset (async, any time):** state=IDLE, `q`=0, prescaler=0, `tc`=0, `busy`=0, `zero`=1. Takes effect immediately, mid-count included.
- **`load` (highest synchronous priority, any state):**
  - `q`←`ld_val`, prescaler←0, `tc`←0.
  - Next state is RUN if `ld_val`≠0, else DONE.
  - Loading 0 does not pulse `tc`.
- **IDLE:**
  - `q` holds and `en` is ignored.
  - Leaves IDLE only on `load`.
- **RUN:**
  - `en`=0: prescaler holds; next state PAUSE.
  - `en`=1 and prescaler<`PRESCALE`−1: prescaler+1.
  - `en`=1 and prescaler==`PRESCALE`−1 (a tick): prescaler←0 and `q`←`q`−1.
  - If `q`==1 at the tick: `q`←0, `tc`←1, next state DONE.
- **PAUSE:**
  - `q` and prescaler hold.
  - `en`=1 returns to RUN. The prescaler resumes from its held value; the resume cycle itself counts as an enabled cycle.
- **DONE:**
  - `q`=0, `busy`=0, `zero`=1, `tc` low after its single pulse.
  - `en` is ignored; stays in DONE until `load`.
- **Arithmetic:** unsigned, modulo-free. A decrement from 0 is impossible by construction; no wrap-around to all-ones.
- **`tc`:** cleared every cycle it is not being set (single-cycle pulse).

## Timing
- All state changes happen on the rising `clk` edge except reset.
- **Load latency:** `q`=`ld_val` in the cycle after the edge sampling `load`=1.
- **First decrement:** with `en` held high after load, `q` changes after exactly `PRESCALE` enabled edges. Subsequent decrements come every `PRESCALE` enabled edges.
- **`PRESCALE`=1:** decrement on every enabled edge.
- **Total run time** from load of N (en continuously high) to `tc`: N×`PRESCALE` cycles. `tc` and `q`=0 appear on the same edge.
- **`load` coinciding with a tick, including the final tick:** load wins, no decrement, no `tc`.
- **`en` dropping on a tick edge:** that edge is not a tick (`en` must be 1 to tick).

## Test plan
- **Reset:** assert `reset` asynchronously between edges during a count of 5 → `q`=0, `tc`=0, `busy`=0, `zero`=1 immediately, without waiting for `clk`.
- **Full countdown:** `PRESCALE`=4, load 3, `en`=1 → `q` reads 3, 2, 1, 0 at 4-cycle spacing. `tc` is high exactly one cycle, at the 12th enabled edge after load. `busy` falls with `tc`. `q` stays 0 for ≥10 more cycles.
- **Pause:** load 2, `en`=1 for 2 cycles, `en`=0 for 5 cycles, `en`=1 → first decrement occurs 2 enabled cycles after resume (total 4 enabled). `q` is constant and `busy`=1 during the pause.
- **Load 0:** load 0 → state DONE, `zero`=1, `busy`=0, no `tc` pulse. Loading 15 with `PRESCALE`=1 → `q` counts 15…0 on consecutive edges, single `tc`.
- **Load on the final tick:** load 7 on the edge where `q` would go 1→0 → `q`=7, no `tc`, counting continues.
- **Load in PAUSE and in DONE:** `load` in PAUSE and in DONE → restarts RUN with prescaler cleared; `en` is ignored in IDLE/DONE (`q` unchanged).

Source files
------------

// File: rtl/cntdn4_timer.sv
// rtl/cntdn4_timer.sv - loadable prescaled down-counter with terminal-count pulse
module cntdn4_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] psc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      psc   <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q     <= ld_val;
        psc   <= '0;
        state <= (ld_val != '0) ? RUN : DONE;
      end else begin
        case (state)
          RUN, PAUSE: begin
            // PAUSE shares the RUN step so the resume cycle counts as enabled
            if (!en) begin
              state <= PAUSE;
            end else begin
              state <= RUN;
              if (psc == PS_LAST) begin
                psc <= '0;
                q   <= q - WIDTH'(1);
                if (q == WIDTH'(1)) begin
                  tc    <= 1'b1;
                  state <= DONE;
                end
              end else begin
                psc <= psc + PW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign zero = (q == '0);
  assign busy = (state == RUN) || (state == PAUSE);

endmodule

// File: tb/tb_cntdn4_timer.sv
// tb/tb_cntdn4_timer.sv - directed self-checking bench for cntdn4_timer
module tb_cntdn4_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_a, en_a, load_b, en_b;
  logic [3:0] ld_val_a, ld_val_b;
  logic [3:0] q_a, q_b;
  logic       zero_a, tc_a, busy_a, zero_b, tc_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int tc_count;

  always #5 clk = ~clk;

  cntdn4_timer #(.WIDTH(4), .PRESCALE(4)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .ld_val(ld_val_a), .en(en_a),
    .q(q_a), .zero(zero_a), .tc(tc_a), .busy(busy_a)
  );

  cntdn4_timer #(.WIDTH(4), .PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .ld_val(ld_val_b), .en(en_b),
    .q(q_b), .zero(zero_b), .tc(tc_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int eq, input int etc, input int ebusy);
    check({tag, ".q"},    q_a,    eq);
    check({tag, ".tc"},   tc_a,   etc);
    check({tag, ".busy"}, busy_a, ebusy);
    check({tag, ".zero"}, zero_a, (eq == 0));
  endtask

  initial begin
    reset = 1'b1; load_a = 0; en_a = 0; ld_val_a = 0; load_b = 0; en_b = 0; ld_val_b = 0;
    #1;
    check_a("reset", 0, 0, 0);
    step();
    reset = 1'b0;

    en_a = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_a("idle_en_ignored", 0, 0, 0);
    end

    // full countdown: load 3, tc on the 12th enabled edge
    load_a = 1; ld_val_a = 3; en_a = 1;
    step();
    load_a = 0;
    check_a("load3", 3, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_a("count", 3 - k / 4, (k == 12), (k < 12));
    end
    for (int k = 0; k < 10; k++) begin
      step();
      check_a("done_hold", 0, 0, 0);
    end

    // pause: 2 enabled, 5 paused, decrement 2 enabled after resume
    load_a = 1; ld_val_a = 2; en_a = 1;
    step();
    load_a = 0;
    check_a("load2", 2, 0, 1);
    step(); step();
    check_a("pre_pause", 2, 0, 1);
    en_a = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_a("paused", 2, 0, 1);
    end
    en_a = 1;
    step();
    check_a("resume1", 2, 0, 1);
    step();
    check_a("resume2", 1, 0, 1);

    // load on the final tick wins
    step(); step(); step();
    check_a("before_final", 1, 0, 1);
    load_a = 1; ld_val_a = 7;
    step();
    load_a = 0;
    check_a("load_on_tick", 7, 0, 1);
    for (int k = 0; k < 4; k++) step();
    check_a("after_reload", 6, 0, 1);

    // load in PAUSE clears the prescaler
    step();
    en_a = 0;
    step();
    check_a("pause_again", 6, 0, 1);
    load_a = 1; ld_val_a = 5;
    step();
    load_a = 0; en_a = 1;
    check_a("load_in_pause", 5, 0, 1);
    for (int k = 0; k < 3; k++) step();
    check_a("psc_cleared", 5, 0, 1);
    step();
    check_a("first_dec", 4, 0, 1);

    // load 0 goes straight to DONE without tc
    load_a = 1; ld_val_a = 0;
    step();
    load_a = 0;
    check_a("load0", 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_a("load0_hold", 0, 0, 0);
    end

    // PRESCALE=1: 15 down to 0 on consecutive edges, single tc
    load_b = 1; ld_val_b = 15; en_b = 1;
    step();
    load_b = 0;
    check("b.load15", q_b, 15);
    tc_count = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      check("b.q", q_b, (k < 15) ? 15 - k : 0);
      if (tc_b) tc_count++;
      if (k == 15) check("b.tc_at_15", tc_b, 1);
    end
    check("b.tc_count", tc_count, 1);
    check("b.busy_end", busy_b, 0);

    // async reset between edges mid-count
    load_a = 1; ld_val_a = 5; en_a = 1;
    step();
    load_a = 0;
    for (int k = 0; k < 5; k++) step();
    check_a("pre_reset", 4, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check_a("async_reset", 0, 0, 0);
    #1;
    reset = 1'b0;
    step();
    check_a("post_reset", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
